// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned ITER_COUNT = 32;

  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIXUP,
    DONE
  } state_e;

  // Two's complement negation at data width.
  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
    return DATA_W'(~x + 1'b1);
  endfunction

  // Unsigned magnitude of a signed word; 0x80000000 maps to itself, which is correct unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? negate(x) : x;
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Working registers (A, Q, M) and the shared 33-bit adder for Booth multiply
// and restoring divide, plus the architectural HI/LO registers.
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              fixup_i,
  input  logic              op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              b_zero_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic              q1_q, q1_d;
  logic              op_q, op_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              b_zero_q, b_zero_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic [DATA_W:0]   add_a, add_b, sum;
  logic              sub;

  // Adder operands: Booth adds/subtracts sign-extended M; divide trial-subtracts M from shifted A.
  always_comb begin
    add_a = '0;
    add_b = '0;
    sub   = 1'b0;
    if (op_q == MD_MULT) begin
      add_a = {acc_q[DATA_W-1], acc_q};
      add_b = (q_q[0] ^ q1_q) ? {m_q[DATA_W-1], m_q} : '0;
      sub   = q_q[0] & ~q1_q;
    end else begin
      add_a = {acc_q, q_q[DATA_W-1]};
      add_b = {1'b0, m_q};
      sub   = 1'b1;
    end
    sum = sub ? (add_a - add_b) : (add_a + add_b);
  end

  // Next-state for working and result registers.
  always_comb begin
    acc_d     = acc_q;
    q_d       = q_q;
    m_d       = m_q;
    q1_d      = q1_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (load_i) begin
      acc_d = '0;
      q1_d  = 1'b0;
      op_d  = op_i;
      if (op_i == MD_DIV) begin
        q_d       = magnitude(a_i);
        m_d       = magnitude(b_i);
        neg_quo_d = a_i[DATA_W-1] ^ b_i[DATA_W-1];
        neg_rem_d = a_i[DATA_W-1];
        b_zero_d  = (b_i == '0);
      end else begin
        q_d       = b_i;
        m_d       = a_i;
        neg_quo_d = 1'b0;
        neg_rem_d = 1'b0;
        b_zero_d  = 1'b0;
      end
    end else if (step_i) begin
      if (op_q == MD_MULT) begin
        acc_d = sum[DATA_W:1];
        q_d   = {sum[0], q_q[DATA_W-1:1]};
        q1_d  = q_q[0];
      end else if (sum[DATA_W]) begin
        acc_d = add_a[DATA_W-1:0];
        q_d   = {q_q[DATA_W-2:0], 1'b0};
      end else begin
        acc_d = sum[DATA_W-1:0];
        q_d   = {q_q[DATA_W-2:0], 1'b1};
      end
    end else if (fixup_i) begin
      // Signs are applied on the way into HI/LO so partial results never show.
      if (op_q == MD_MULT) begin
        hi_d = acc_q;
        lo_d = q_q;
      end else begin
        hi_d = neg_rem_q ? negate(acc_q) : acc_q;
        lo_d = neg_quo_q ? negate(q_q) : q_q;
      end
    end
  end

  // Register update with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      q_q       <= '0;
      m_q       <= '0;
      q1_q      <= 1'b0;
      op_q      <= MD_MULT;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      acc_q     <= acc_d;
      q_q       <= q_d;
      m_q       <= m_d;
      q1_q      <= q1_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign b_zero_o = b_zero_q;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply/divide sequencer: FSM plus iteration counter
// driving the datapath strobes; busy/done/div_zero are registered.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic             load_c, step_c, fixup_c;
  logic             b_zero;

  // Next-state, counter and datapath strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    fixup_c = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          load_c  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = b_zero ? DONE : ITER;
      end
      ITER: begin
        step_c = 1'b1;
        if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
          cnt_d   = '0;
          state_d = FIXUP;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      FIXUP: begin
        fixup_c = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d == LOAD) || (state_d == ITER) || (state_d == FIXUP);
    done_d     = (state_d == DONE);
    div_zero_d = (state_q == LOAD) && (state_d == DONE);
  end

  // State, counter and status flags; reset aborts any operation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  muldiv_datapath u_datapath (
    .clock    (clock),
    .reset    (reset),
    .load_i   (load_c),
    .step_i   (step_c),
    .fixup_i  (fixup_c),
    .op_i     (op),
    .a_i      (a_in),
    .b_i      (b_in),
    .b_zero_o (b_zero),
    .hi_o     (hi),
    .lo_o     (lo)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and random checks of muldiv_sequencer against an arithmetic model.
module tb_muldiv_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        exp_dz = 1'b0;
  int          exp_lat = 34;

  muldiv_sequencer dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: signed 64-bit product, or C-style truncating divide/remainder.
  task automatic model(input logic mop, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    logic [63:0] pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    exp_dz  = 1'b0;
    exp_lat = 34;
    if (mop == 1'b0) begin
      r  = sa * sb;
      pv = r;
      exp_hi = pv[63:32];
      exp_lo = pv[31:0];
    end else if (b == 32'd0) begin
      exp_dz  = 1'b1;
      exp_lat = 1;
    end else begin
      r  = sa / sb;
      pv = r;
      exp_lo = pv[31:0];
      r  = sa % sb;
      pv = r;
      exp_hi = pv[31:0];
    end
  endtask

  // Issue one operation; pulse_n > 0 re-pulses start during cycle N+pulse_n+1.
  task automatic run_op(input string tag, input logic mop, input logic [31:0] a,
                        input logic [31:0] b, input int pulse_n);
    int n;
    bit got;
    bit busy_bad;
    model(mop, a, b);
    @(negedge clock);
    start = 1'b1;
    op    = mop;
    a_in  = a;
    b_in  = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    op    = 1'($urandom);
    a_in  = $urandom;
    b_in  = $urandom;
    chk({tag, "_busy_load"}, 64'(busy), 64'(1));
    n = 0;
    got = 1'b0;
    busy_bad = 1'b0;
    while (!got && n < 60) begin
      @(posedge clock);
      #1;
      n++;
      start = (n == pulse_n);
      if (done) got = 1'b1;
      else if (busy !== 1'b1) busy_bad = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_busy_run"}, 64'(busy_bad), 64'(0));
    chk({tag, "_busy_done"}, 64'(busy), 64'(0));
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    chk({tag, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
    @(posedge clock);
    #1;
    chk({tag, "_after_done"}, {62'd0, done, busy}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int pulses;
    logic [31:0] ra, rb;
    logic rop;
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a_in  = '0;
    b_in  = '0;
    #23;
    chk("reset_state", {busy, done, div_zero, hi, lo}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 0);
    chk("mul_7_m3_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
    chk("mul_min_min_const", {hi, lo}, 64'h4000_0000_0000_0000);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_m7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_100_7", 1'b1, 32'd100, 32'd7, 0);
    chk("div_100_7_const", {hi, lo}, {32'd2, 32'd14});
    run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_min_m1_const", {hi, lo}, 64'h0000_0000_8000_0000);

    run_op("div_prep", 1'b1, 32'h451, 32'h20, 0);
    run_op("div_zero", 1'b1, 32'd5, 32'd0, 0);
    chk("div_zero_const", {hi, lo}, {32'h11, 32'h22});

    run_op("mul_restart", 1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 9);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (done) pulses++;
    end
    chk("restart_no_extra_done", 64'(pulses), 64'd0);

    @(negedge clock);
    start = 1'b1;
    op    = 1'b1;
    a_in  = 32'd1000;
    b_in  = 32'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_clear", {31'd0, busy, hi, lo}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (done || busy) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    run_op("mul_3_4", 1'b0, 32'd3, 32'd4, 0);
    chk("mul_3_4_const", {hi, lo}, 64'd12);

    for (int i = 0; i < 24; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = pick();
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : pick();
      run_op($sformatf("rand%0d", i), rop, ra, rb, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
